sram_read_arbiter: RTL and testbench
====================================

# sram_read_arbiter

Round-robin arbiter that shares the single read port of the fixed-latency dual-port SRAM (`sram_dualport_latency_5`) among `N_REQ` requesters. It issues at most one read per cycle and tags each issued read with its requester index in a `LATENCY`-deep pipeline. When the data returns, it steers the response valid back to the owning requester. It sits between several read clients (e.g. per-queue FIFO prefetchers) and one SRAM instance, and flags any mismatch between its tag pipeline and the SRAM's own valid.

## Interface

Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 8, SRAM data width
- `DEPTH`, 8, SRAM depth; `W_ADDR = $clog2(DEPTH)`
- `LATENCY`, 5, SRAM read latency in cycles (≥1)

Ports:
- `clk_i`, in, 1, clock; all logic on rising edge
- `rst_ni`, in, 1, reset; synchronous, active-low
- `req_i`, in, N_REQ, per-requester read request
- `addr_i`, in, N_REQ*W_ADDR, packed addresses; requester k uses bits [k*W_ADDR +: W_ADDR]
- `gnt_o`, out, N_REQ, one-hot-or-zero grant, same cycle as request
- `sram_ren_o`, out, 1, to SRAM `ren_i`
- `sram_raddr_o`, out, W_ADDR, to SRAM `raddr_i`
- `sram_data_i`, in, WIDTH, from SRAM `data_o`
- `sram_vld_i`, in, 1, from SRAM `vld_o`
- `rsp_vld_o`, out, N_REQ, one-hot-or-zero response valid
- `rsp_data_o`, out, WIDTH, response data, shared by all requesters
- `err_o`, out, 1, sticky tag/valid mismatch flag

## Operation

- Arbitration is combinational. The search starts at index `(last_ptr+1) mod N_REQ` and ascends with wrap; the first set `req_i` bit wins.
- `gnt_o[k]=1` for the winner only. `sram_ren_o = |gnt_o`. `sram_raddr_o` = the winner's address slice. When there is no grant, `sram_raddr_o` = 0.
- `last_ptr` register: updates to the winner index on any grant and holds otherwise. Reset value is `N_REQ-1`, so requester 0 has top priority after reset.
- Requester protocol: hold `req_i[k]` and its address stable until `gnt_o[k]` is seen. It may deassert, or issue a new request, in the cycle after the grant.
- Fairness: a continuously asserted request is granted within `N_REQ` cycles. With all requesters active, grants rotate 0,1,…,N_REQ-1,0,…
- Tag pipeline: `LATENCY` stages, each holding `{vld, id[$clog2(N_REQ)]}`. Stage 0 captures `{sram_ren_o, winner}` every cycle, and stage i captures stage i-1. There are no stalls: the SRAM read port accepts every cycle, so the pipeline always advances.
- Response: `rsp_vld_o[tail.id] = tail.vld`, all other bits 0. `rsp_data_o = sram_data_i` (combinational pass-through; not gated by valid).
- Error check: `err_o` sets when `sram_vld_i != tail.vld` in any cycle. It then holds 1 until reset.
- No write-port involvement; the SRAM write port is owned elsewhere. Read-after-write ordering is the SRAM's concern.

## Timing

- Grant: same cycle as `req_i`, with zero-cycle request-to-grant.
- Read latency: a grant in cycle t produces `rsp_vld_o` in cycle t+LATENCY (exactly `LATENCY` rising edges later). This matches the SRAM `vld_o` timing.
- Throughput: one read per cycle, with back-to-back grants allowed, including to the same requester when it is the only one requesting.
- Reset (`rst_ni=0` at an edge):
  - `last_ptr` becomes N_REQ-1.
  - All pipeline valids are cleared; `err_o` becomes 0.
  - Outputs after reset: `rsp_vld_o`=0, `err_o`=0. `gnt_o`/`sram_ren_o` follow `req_i` combinationally, but while `rst_ni=0`, `gnt_o`=0 and `sram_ren_o`=0.
- Reset mid-operation: in-flight reads are dropped and no response is delivered. The SRAM must be reset in the same cycle; otherwise `err_o` may set.
- Simultaneous events: a new grant and a response to the same requester in one cycle are independent and both occur.
- Wrap: the priority search wraps from N_REQ-1 to 0, and `last_ptr=N_REQ-1` makes index 0 first.

## Test plan

- Reset then single request: `req_i=4'b0100`, addr2=5 in cycle 0 → `gnt_o=4'b0100`, `sram_raddr_o=5` in cycle 0; `rsp_vld_o=4'b0100` with SRAM data of address 5 in cycle 5; `err_o`=0.
- All requesters held, `req_i=4'b1111` for 8 cycles → grants 0,1,2,3,0,1,2,3; responses in the same order, each 5 cycles after its grant.
- Round-robin skip and wrap: after a grant to 3, `req_i=4'b1010` → grant 1, then 3, then 1; after a grant to 3, `req_i=4'b0001` → grant 0.
- Back-to-back single requester: `req_i=4'b0001`, addrs 0..7 on consecutive cycles → 8 consecutive grants; `rsp_vld_o[0]` is high for 8 consecutive cycles starting 5 cycles later, with data matching addresses 0..7 in order.
- Reset mid-flight: 3 grants issued, then `rst_ni=0` for 1 cycle two cycles later (arbiter and SRAM together) → no `rsp_vld_o` for those reads; `err_o` stays 0; the next request goes to requester 0 first.
- Mismatch injection: force `sram_vld_i=1` with an empty pipeline → `err_o`=1 the next cycle, held until `rst_ni=0`.

Source files
------------

// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter
// Round-robin arbiter that shares one fixed-latency SRAM read port among
// N_REQ requesters. Each issued read carries its requester index down a
// LATENCY-deep tag pipeline so the returning data can be steered back to
// its owner. A sticky error flag reports any disagreement between the tag
// pipeline and the SRAM's own read-valid.

module sram_read_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 5,
    localparam int W_ADDR = $clog2(DEPTH),
    localparam int W_ID   = $clog2(N_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*W_ADDR-1:0]   addr_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic                      sram_ren_o,
    output logic [W_ADDR-1:0]         sram_raddr_o,
    input  logic [WIDTH-1:0]          sram_data_i,
    input  logic                      sram_vld_i,
    output logic [N_REQ-1:0]          rsp_vld_o,
    output logic [WIDTH-1:0]          rsp_data_o,
    output logic                      err_o
);

    // One extra bit so (last_ptr + offset) cannot overflow before the wrap.
    localparam logic [W_ID:0] N_REQ_EXT = (W_ID+1)'(N_REQ);

    logic [N_REQ-1:0]  w_req;
    logic [N_REQ-1:0]  w_gnt;
    logic [W_ID-1:0]   w_win_id;
    logic              w_any;
    logic [W_ID:0]     w_idx;
    logic [W_ADDR-1:0] w_raddr;
    logic [N_REQ-1:0]  w_rsp_vld;

    logic [W_ID-1:0]   r_last_ptr;
    logic              r_tag_vld [LATENCY];
    logic [W_ID-1:0]   r_tag_id  [LATENCY];
    logic              r_err;

    // Requests are ignored while reset is held, so nothing is granted then.
    assign w_req = req_i & {N_REQ{rst_ni}};

    // Round-robin search starting just after the last winner, wrapping at N_REQ.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise a path that skips the assignment infers a latch.
        w_gnt    = '0;
        w_win_id = '0;
        w_any    = 1'b0;
        w_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = {1'b0, r_last_ptr} + (W_ID+1)'(i);
            if (w_idx >= N_REQ_EXT) begin
                w_idx = w_idx - N_REQ_EXT;
            end
            if (!w_any && w_req[w_idx[W_ID-1:0]]) begin
                w_any    = 1'b1;
                w_win_id = w_idx[W_ID-1:0];
            end
        end
        if (w_any) begin
            w_gnt[w_win_id] = 1'b1;
        end
    end

    // Read address is the winner's slice, or zero when nobody is granted.
    always_comb begin
        w_raddr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                w_raddr = addr_i[k*W_ADDR +: W_ADDR];
            end
        end
    end

    // Remember the last winner; reset makes requester 0 the first candidate.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            r_last_ptr <= W_ID'(N_REQ-1);
        end else if (w_any) begin
            r_last_ptr <= w_win_id;
        end
    end

    // Valid half of the tag pipeline: always advances, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_tag_vld[i] <= 1'b0;
            end
        end else begin
            r_tag_vld[0] <= w_any;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
            end
        end
    end

    // Requester-index half of the tag pipeline, qualified by the valid bits.
    always_ff @(posedge clk_i) begin
        // NOTE: the id payload is deliberately left unreset; the stage valid
        // alone decides whether it means anything.
        r_tag_id[0] <= w_win_id;
        for (int i = 1; i < LATENCY; i++) begin
            r_tag_id[i] <= r_tag_id[i-1];
        end
    end

    // Sticky flag: SRAM valid must agree with the tail of the tag pipeline.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (sram_vld_i != r_tag_vld[LATENCY-1]) begin
            r_err <= 1'b1;
        end
    end

    // Steer the returning valid to the requester recorded at the tail.
    always_comb begin
        w_rsp_vld = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_rsp_vld[k] = r_tag_vld[LATENCY-1] && (r_tag_id[LATENCY-1] == W_ID'(k));
        end
    end

    assign gnt_o        = w_gnt;
    assign sram_ren_o   = w_any;
    assign sram_raddr_o = w_raddr;
    assign rsp_vld_o    = w_rsp_vld;
    assign rsp_data_o   = sram_data_i;
    assign err_o        = r_err;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter with a behavioural 5-cycle SRAM read port whose
// word at address a is 8'hA0 + a.

module tb_sram_read_arbiter;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int LATENCY = 5;

    logic        clk_i;
    logic        rst_ni;
    logic [3:0]  req_i;
    logic [11:0] addr_i;
    logic [3:0]  gnt_o;
    logic        sram_ren_o;
    logic [2:0]  sram_raddr_o;
    logic [7:0]  sram_data_i;
    logic        sram_vld_i;
    logic [3:0]  rsp_vld_o;
    logic [7:0]  rsp_data_o;
    logic        err_o;

    logic        force_vld;
    int          n_pass  = 0;
    int          n_total = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [11:0] addr;
        logic [3:0]  gnt;
        logic [2:0]  raddr;
        logic [3:0]  rsp;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[$];

    sram_read_arbiter #(
        .N_REQ  (N_REQ),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .gnt_o       (gnt_o),
        .sram_ren_o  (sram_ren_o),
        .sram_raddr_o(sram_raddr_o),
        .sram_data_i (sram_data_i),
        .sram_vld_i  (sram_vld_i),
        .rsp_vld_o   (rsp_vld_o),
        .rsp_data_o  (rsp_data_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural SRAM read port: fixed latency, valids cleared by reset.
    logic       m_vld  [LATENCY];
    logic [2:0] m_addr [LATENCY];

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) m_vld[i] <= 1'b0;
        end else begin
            m_vld[0] <= sram_ren_o;
            for (int i = 1; i < LATENCY; i++) m_vld[i] <= m_vld[i-1];
        end
        m_addr[0] <= sram_raddr_o;
        for (int i = 1; i < LATENCY; i++) m_addr[i] <= m_addr[i-1];
    end

    assign sram_vld_i  = m_vld[LATENCY-1] | force_vld;
    assign sram_data_i = 8'hA0 + {5'd0, m_addr[LATENCY-1]};

    function automatic logic [11:0] pk(input logic [2:0] a3, input logic [2:0] a2,
                                       input logic [2:0] a1, input logic [2:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs, check this cycle's outputs, advance to the next.
    task automatic cycle(input logic rst_n, input logic [3:0] req, input logic [11:0] addr,
                         input logic [3:0] eg, input logic [2:0] er, input logic [3:0] ersp,
                         input logic [7:0] ed, input logic ee, input string tag);
        rst_ni = rst_n;
        req_i  = req;
        addr_i = addr;
        #2;
        check({tag, ".gnt"},   32'(gnt_o),        32'(eg));
        check({tag, ".ren"},   32'(sram_ren_o),   32'(|eg));
        check({tag, ".raddr"}, 32'(sram_raddr_o), 32'(er));
        check({tag, ".rsp"},   32'(rsp_vld_o),    32'(ersp));
        check({tag, ".err"},   32'(err_o),        32'(ee));
        if (ersp != 4'b0000) begin
            check({tag, ".data"}, 32'(rsp_data_o), 32'(ed));
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic add(input logic rst_n, input logic [3:0] req, input logic [11:0] addr,
                       input logic [3:0] gnt, input logic [2:0] raddr,
                       input logic [3:0] rsp, input logic [7:0] data);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.addr = addr;
        v.gnt = gnt; v.raddr = raddr; v.rsp = rsp; v.data = data;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a_all;
        a_all     = pk(3'd4, 3'd3, 3'd2, 3'd1);
        rst_ni    = 1'b0;
        req_i     = '0;
        addr_i    = '0;
        force_vld = 1'b0;

        // Reset held, requests ignored; then single request from 2 (addr 5).
        add(1'b0, 4'b1111, a_all,                     4'b0000, 3'd0, 4'b0000, 8'h00);
        add(1'b1, 4'b0100, pk(3'd0,3'd5,3'd0,3'd0),   4'b0100, 3'd5, 4'b0000, 8'h00);
        add(1'b1, 4'b0000, 12'h000,                   4'b0000, 3'd0, 4'b0000, 8'h00);
        add(1'b1, 4'b0000, 12'h000,                   4'b0000, 3'd0, 4'b0000, 8'h00);
        add(1'b1, 4'b0000, 12'h000,                   4'b0000, 3'd0, 4'b0000, 8'h00);
        add(1'b1, 4'b0000, 12'h000,                   4'b0000, 3'd0, 4'b0000, 8'h00);
        add(1'b1, 4'b0000, 12'h000,                   4'b0000, 3'd0, 4'b0100, 8'hA5);
        // Reset again, then all four requesters held for 8 cycles.
        add(1'b0, 4'b1111, a_all, 4'b0000, 3'd0, 4'b0000, 8'h00);
        add(1'b1, 4'b1111, a_all, 4'b0001, 3'd1, 4'b0000, 8'h00);
        add(1'b1, 4'b1111, a_all, 4'b0010, 3'd2, 4'b0000, 8'h00);
        add(1'b1, 4'b1111, a_all, 4'b0100, 3'd3, 4'b0000, 8'h00);
        add(1'b1, 4'b1111, a_all, 4'b1000, 3'd4, 4'b0000, 8'h00);
        add(1'b1, 4'b1111, a_all, 4'b0001, 3'd1, 4'b0000, 8'h00);
        add(1'b1, 4'b1111, a_all, 4'b0010, 3'd2, 4'b0001, 8'hA1);
        add(1'b1, 4'b1111, a_all, 4'b0100, 3'd3, 4'b0010, 8'hA2);
        add(1'b1, 4'b1111, a_all, 4'b1000, 3'd4, 4'b0100, 8'hA3);
        add(1'b1, 4'b0000, a_all, 4'b0000, 3'd0, 4'b1000, 8'hA4);
        add(1'b1, 4'b0000, a_all, 4'b0000, 3'd0, 4'b0001, 8'hA1);
        add(1'b1, 4'b0000, a_all, 4'b0000, 3'd0, 4'b0010, 8'hA2);
        add(1'b1, 4'b0000, a_all, 4'b0000, 3'd0, 4'b0100, 8'hA3);
        add(1'b1, 4'b0000, a_all, 4'b0000, 3'd0, 4'b1000, 8'hA4);
        add(1'b1, 4'b0000, a_all, 4'b0000, 3'd0, 4'b0000, 8'h00);

        repeat (2) @(posedge clk_i);
        #1;

        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].req, vecs[i].addr, vecs[i].gnt, vecs[i].raddr,
                  vecs[i].rsp, vecs[i].data, 1'b0, $sformatf("vec%0d", i));
        end

        // Skip and wrap: last winner was 3.
        cycle(1'b1, 4'b1010, pk(3'd7,3'd0,3'd6,3'd0), 4'b0010, 3'd6, 4'b0000, 8'h00, 1'b0, "rr0");
        cycle(1'b1, 4'b1010, pk(3'd7,3'd0,3'd6,3'd0), 4'b1000, 3'd7, 4'b0000, 8'h00, 1'b0, "rr1");
        cycle(1'b1, 4'b1010, pk(3'd7,3'd0,3'd6,3'd0), 4'b0010, 3'd6, 4'b0000, 8'h00, 1'b0, "rr2");
        cycle(1'b1, 4'b1000, pk(3'd7,3'd0,3'd6,3'd0), 4'b1000, 3'd7, 4'b0000, 8'h00, 1'b0, "rr3");
        cycle(1'b1, 4'b0001, pk(3'd0,3'd0,3'd0,3'd2), 4'b0001, 3'd2, 4'b0000, 8'h00, 1'b0, "rr4");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0010, 8'hA6, 1'b0, "rr5");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b1000, 8'hA7, 1'b0, "rr6");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0010, 8'hA6, 1'b0, "rr7");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b1000, 8'hA7, 1'b0, "rr8");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0001, 8'hA2, 1'b0, "rr9");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "rr10");

        // Back-to-back reads from requester 0, addresses 0..7.
        for (int c = 0; c < 14; c++) begin
            cycle(1'b1, (c < 8) ? 4'b0001 : 4'b0000, pk(3'd0, 3'd0, 3'd0, 3'(c)),
                  (c < 8) ? 4'b0001 : 4'b0000, (c < 8) ? 3'(c) : 3'd0,
                  (c >= 5 && c < 13) ? 4'b0001 : 4'b0000, 8'hA0 + 8'(c - 5), 1'b0,
                  $sformatf("b2b%0d", c));
        end

        // Reset mid-flight: three reads issued, reset two cycles later.
        cycle(1'b1, 4'b1111, pk(3'd3,3'd2,3'd1,3'd5), 4'b0010, 3'd1, 4'b0000, 8'h00, 1'b0, "mid0");
        cycle(1'b1, 4'b1111, pk(3'd3,3'd2,3'd1,3'd5), 4'b0100, 3'd2, 4'b0000, 8'h00, 1'b0, "mid1");
        cycle(1'b1, 4'b1111, pk(3'd3,3'd2,3'd1,3'd5), 4'b1000, 3'd3, 4'b0000, 8'h00, 1'b0, "mid2");
        cycle(1'b1, 4'b0000, 12'h000,                  4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "mid3");
        cycle(1'b0, 4'b1111, pk(3'd3,3'd2,3'd1,3'd5), 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "mid4");
        cycle(1'b1, 4'b1111, pk(3'd3,3'd2,3'd1,3'd5), 4'b0001, 3'd5, 4'b0000, 8'h00, 1'b0, "mid5");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "mid6");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "mid7");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "mid8");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "mid9");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0001, 8'hA5, 1'b0, "mid10");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "mid11");

        // Spurious SRAM valid with an empty pipeline: sticky error until reset.
        force_vld = 1'b1;
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "err0");
        force_vld = 1'b0;
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b1, "err1");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b1, "err2");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b1, "err3");
        cycle(1'b0, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b1, "err4");
        cycle(1'b1, 4'b0000, 12'h000, 4'b0000, 3'd0, 4'b0000, 8'h00, 1'b0, "err5");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
